// File: rtl/data_array_seq_pkg.sv
// Shared defaults and the sequencer state type for the data array front end.
package data_array_seq_pkg;

  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 32;
  localparam int RSP_DEPTH_DEF = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/data_array_rsp_fifo.sv
// Read-response buffer: DEPTH entries, in-order, combinational head output.
module data_array_rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             push_i,
  input  logic [DATA_W-1:0]                push_data_i,
  input  logic                             pop_i,
  output logic [$clog2(DEPTH+1)-1:0]       count_o,
  output logic                             valid_o,
  output logic [DATA_W-1:0]                data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign pop_ok  = pop_i && valid_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is governed by count_q alone.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clock) begin
    if (reset_n) assert (!(push_i && full && !pop_ok));
  end

endmodule

// File: rtl/data_array_seq.sv
// Request sequencer for a single-port data array with 2-cycle read responses.
// Optional zero-fill after reset: define DATA_ARRAY_SEQ_ZERO_INIT_EN.
module data_array_seq
  import data_array_seq_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wmask,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic             run;
  logic             accept;
  logic             pop;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] rsp_count;
  logic [OCC_W-1:0] occupancy;

`ifdef DATA_ARRAY_SEQ_ZERO_INIT_EN
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              init_wr;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == '1) state_d = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // The array must stay idle while reset is held even though the state reads INIT.
  assign init_wr = (state_q == INIT) && reset_n;
  assign run     = (state_q == RUN);
  assign busy    = (state_q == INIT);
`else
  logic run_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign run  = run_q;
  assign busy = 1'b0;
`endif

  // Reserve a buffer slot for every read already issued; a same-cycle pop frees one.
  assign pop       = rsp_valid && rsp_ready;
  assign occupancy = OCC_W'(rsp_count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign req_ready = run && (occupancy < OCC_W'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign inflight_d = accept && !req_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) inflight_q <= 1'b0;
    else          inflight_q <= inflight_d;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = req_addr;
    sram_wdata = req_wdata;
    sram_wmask = req_wmask;
    if (accept) begin
      sram_en    = 1'b1;
      sram_wmode = req_write;
    end
`ifdef DATA_ARRAY_SEQ_ZERO_INIT_EN
    if (init_wr) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_addr_q;
      sram_wdata = '0;
      sram_wmask = '1;
    end
`endif
  end

  data_array_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (inflight_q),
    .push_data_i (sram_rdata),
    .pop_i       (pop),
    .count_o     (rsp_count),
    .valid_o     (rsp_valid),
    .data_o      (rsp_rdata)
  );

endmodule

// File: tb/tb_data_array_seq.sv
// Directed bench for data_array_seq with a behavioural single-port array model.
module tb_data_array_seq;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
`ifdef DATA_ARRAY_SEQ_ZERO_INIT_EN
  localparam logic        INIT_ON = 1'b1;
  localparam logic [31:0] PRELOAD = 32'hDEAD_BEEF;
`else
  localparam logic        INIT_ON = 1'b0;
  localparam logic [31:0] PRELOAD = 32'h0000_0000;
`endif

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [DATA_W-1:0] sram_wdata;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_rdata;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_data [8];

  data_array_seq dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic        preload;
  logic [31:0] mem [0:4095];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= PRELOAD;
    end else if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < MASK_W; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    idle_inputs();
    req_valid = 1'b1;
    req_addr  = 12'h005;
    cyc();
    preload = 1'b0;
    repeat (2) cyc();
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_tests++;
    if (sram_en !== 1'b0) begin n_fail++; $display("FAIL rst_sram_en: got %b want 0", sram_en); end
    n_tests++;
    if (busy !== INIT_ON) begin n_fail++; $display("FAIL rst_busy: got %b want %b", busy, INIT_ON); end
    req_valid = 1'b0;
    reset_n   = 1'b1;
`ifndef DATA_ARRAY_SEQ_ZERO_INIT_EN
    cyc();
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_after_release: got ready=%b busy=%b want ready=1 busy=0", req_ready, busy);
    end
`endif
  endtask

`ifdef DATA_ARRAY_SEQ_ZERO_INIT_EN
  task automatic test_init();
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < 4096; i++) begin
      if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_wdata !== 32'h0 ||
          sram_wmask !== 4'hF || sram_addr !== ADDR_W'(i) || busy !== 1'b1 || req_ready !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      cyc();
      #1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL init_sweep: %0d bad cycles (first at %0d) want 0", bad, first_bad);
    end
    n_tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || sram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: got busy=%b ready=%b en=%b want 0 1 0", busy, req_ready, sram_en);
    end
  endtask
`endif

  task automatic test_mask_write_read();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h010;
    req_wdata = 32'hA5A5_A5A5;
    req_wmask = 4'b0101;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 12'h010 ||
        sram_wdata !== 32'hA5A5_A5A5 || sram_wmask !== 4'b0101) begin
      n_fail++;
      $display("FAIL write_drive: got rdy=%b en=%b wm=%b a=%h d=%h m=%b want 1 1 1 010 a5a5a5a5 0101",
               req_ready, sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask);
    end
    cyc();
    req_write = 1'b0;
    req_wdata = '0;
    req_wmask = '0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 12'h010 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_drive: got rdy=%b en=%b wm=%b a=%h rv=%b want 1 1 0 010 0",
               req_ready, sram_en, sram_wmode, sram_addr, rsp_valid);
    end
    cyc();
    idle_inputs();
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_too_early: got %b want 0", rsp_valid); end
    n_tests++;
    if (sram_en !== 1'b0) begin n_fail++; $display("FAIL sram_idle: got %b want 0", sram_en); end
    cyc();
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00A5_00A5) begin
      n_fail++;
      $display("FAIL masked_read: got v=%b d=%h want v=1 d=00a500a5", rsp_valid, rsp_rdata);
    end
    cyc();
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp: got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int ready_bad = 0;
    for (int i = 0; i < 8; i++) exp_data[i] = 32'h1111_1111 * (i + 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 12'h100 + ADDR_W'(i);
      req_wdata = exp_data[i];
      req_wmask = 4'hF;
      #1;
      if (req_ready !== 1'b1 || busy !== 1'b0) ready_bad++;
      cyc();
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h100 + ADDR_W'(c);
      end else begin
        idle_inputs();
      end
      #1;
      if (c < 8 && req_ready !== 1'b1) ready_bad++;
      n_tests++;
      if (c < 2) begin
        if (rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_early_%0d: got v=%b want 0", c, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data[c-2]) begin
        n_fail++;
        $display("FAIL b2b_rsp_%0d: got v=%b d=%h want v=1 d=%h", c - 2, rsp_valid, rsp_rdata, exp_data[c-2]);
      end
      cyc();
    end
    n_tests++;
    if (ready_bad != 0) begin n_fail++; $display("FAIL b2b_ready: got %0d stalls want 0", ready_bad); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int rcv = 0;
    int unstable = 0;
    logic have = 1'b0;
    logic took;
    logic [31:0] held = '0;
    rsp_ready = 1'b0;
    req_write = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = (acc < 4);
      req_addr  = 12'h100 + ADDR_W'(acc);
      #1;
      took = req_valid && req_ready;
      if (rsp_valid === 1'b1) begin
        if (!have) begin held = rsp_rdata; have = 1'b1; end
        else if (rsp_rdata !== held) unstable++;
      end
      cyc();
      if (took) acc++;
    end
    req_valid = (acc < 4);
    req_addr  = 12'h100 + ADDR_W'(acc);
    #1;
    n_tests++;
    if (acc != 2 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: got accepted=%0d ready=%b want 2 0", acc, req_ready);
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data[0] || unstable != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b d=%h changes=%0d want v=1 d=%h changes=0",
               rsp_valid, rsp_rdata, unstable, exp_data[0]);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && rcv < 4; c++) begin
      req_valid = (acc < 4);
      req_addr  = 12'h100 + ADDR_W'(acc);
      #1;
      took = req_valid && req_ready;
      if (rsp_valid === 1'b1) begin
        n_tests++;
        if (rsp_rdata !== exp_data[rcv]) begin
          n_fail++;
          $display("FAIL bp_rsp_%0d: got %h want %h", rcv, rsp_rdata, exp_data[rcv]);
        end
        rcv++;
      end
      cyc();
      if (took) acc++;
    end
    idle_inputs();
    n_tests++;
    if (rcv != 4 || acc != 4) begin
      n_fail++;
      $display("FAIL bp_drain: got received=%0d accepted=%0d want 4 4", rcv, acc);
    end
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    int post = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 12'h103;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rd_accept: got %b want 1", req_ready); end
    cyc();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rsp_now: got v=%b ready=%b want 0 0", rsp_valid, req_ready);
    end
    repeat (2) begin
      cyc();
      if (rsp_valid !== 1'b0) seen++;
    end
    reset_n = 1'b1;
    for (int n = 0; n < 4200 && post < 6; n++) begin
      #1;
      if (rsp_valid !== 1'b0) seen++;
      if (busy === 1'b0) post++;
      cyc();
    end
    #1;
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d response cycles want 0", seen); end
    n_tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_recover: got busy=%b ready=%b want 0 1", busy, req_ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    preload = 1'b1;
    test_reset();
`ifdef DATA_ARRAY_SEQ_ZERO_INIT_EN
    test_init();
`endif
    test_mask_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
